// File: rtl/sram_arb_ctrl_pkg.sv
// ============================================================================
// Module      : sram_arb_ctrl_pkg
// Description : Shared types and constants for the SRAM arbiter/controller.
//               Holds the controller FSM state encoding and the number of
//               requesting ports.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sram_arb_ctrl_pkg;

    // Number of requesting ports served by the controller.
    localparam int c_num_ports = 2;

    // Controller FSM: normal request service, or zero-fill sweep.
    typedef enum logic [0:0] {
        SERVE = 1'b0,
        CLEAR = 1'b1
    } state_t;

endpackage : sram_arb_ctrl_pkg

`default_nettype wire

// File: rtl/sram_arb_ctrl_rr_arbiter_2.sv
// ============================================================================
// Module      : rr_arbiter_2
// Description : Two-way round-robin arbiter. Grants at most one requester per
//               cycle; under contention the port that was not granted last
//               wins. The last-granted pointer resets to port 1 so port 0
//               wins the first contention.
// Ports       : CLK      - clock
//               reset    - asynchronous active-low reset
//               en       - grant enable (low forces no grant)
//               req      - per-port request
//               gnt      - one-hot grant
//               gnt_idx  - index of the granted port (valid when |gnt)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter_2
    import sram_arb_ctrl_pkg::*;
(
    input  logic                   CLK,
    input  logic                   reset,
    input  logic                   en,
    input  logic [c_num_ports-1:0] req,
    output logic [c_num_ports-1:0] gnt,
    output logic                   gnt_idx
);

    logic r_last;

    always_comb begin
        gnt     = '0;
        gnt_idx = 1'b0;
        if (en) begin
            case (req)
                2'b01: begin
                    gnt     = 2'b01;
                    gnt_idx = 1'b0;
                end
                2'b10: begin
                    gnt     = 2'b10;
                    gnt_idx = 1'b1;
                end
                2'b11: begin
                    // Contention: hand the grant to the port not served last.
                    gnt_idx = ~r_last;
                    gnt     = r_last ? 2'b01 : 2'b10;
                end
                default: begin
                    gnt     = '0;
                    gnt_idx = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_last <= 1'b1;
        end else if (|gnt) begin
            r_last <= gnt_idx;
        end
    end

endmodule : rr_arbiter_2

`default_nettype wire

// File: rtl/sram_arb_ctrl.sv
// ============================================================================
// Module      : sram_arb_ctrl
// Description : Two-port single-SRAM controller with round-robin arbitration
//               and a zero-fill sweep. Granted requests drive the SRAM pins
//               combinationally in the grant cycle; read data returns one
//               cycle later on the shared rsp_rdata with a per-port
//               rsp_valid strobe.
// Ports       : CLK, reset           - clock, async active-low reset
//               req_valid/we/addr/wdata - per-port requests (port p in bit /
//                                      slice p)
//               req_ready            - grant strobe per port
//               rsp_valid, rsp_rdata - read response (rdata = Q pass-through)
//               clr_start            - pulse to start zero-fill sweep
//               clr_busy, clr_done   - sweep active / end-of-sweep pulse
//               CEB, WEB, A, D, Q    - SRAM interface (enables active-low)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_arb_ctrl
    import sram_arb_ctrl_pkg::*;
#(
    parameter int numWord     = 2048,
    parameter int numBit      = 32,
    parameter int numWordAddr = $clog2(numWord)
) (
    input  logic                              CLK,
    input  logic                              reset,
    input  logic [c_num_ports-1:0]            req_valid,
    input  logic [c_num_ports-1:0]            req_we,
    input  logic [c_num_ports*numWordAddr-1:0] req_addr,
    input  logic [c_num_ports*numBit-1:0]     req_wdata,
    output logic [c_num_ports-1:0]            req_ready,
    output logic [c_num_ports-1:0]            rsp_valid,
    output logic [numBit-1:0]                 rsp_rdata,
    input  logic                              clr_start,
    output logic                              clr_busy,
    output logic                              clr_done,
    output logic                              CEB,
    output logic                              WEB,
    output logic [numWordAddr-1:0]            A,
    output logic [numBit-1:0]                 D,
    input  logic [numBit-1:0]                 Q
);

    localparam logic [numWordAddr-1:0] c_last_addr = numWordAddr'(numWord - 1);

    state_t                   r_state;
    state_t                   w_state_next;
    logic [numWordAddr-1:0]   r_cnt;
    logic [numWordAddr-1:0]   w_cnt_next;
    logic [c_num_ports-1:0]   r_rsp_valid;
    logic                     r_clr_done;

    logic                     w_arb_en;
    logic [c_num_ports-1:0]   w_gnt;
    logic                     w_gnt_idx;
    logic                     w_sel_we;
    logic [numWordAddr-1:0]   w_sel_addr;
    logic [numBit-1:0]        w_sel_wdata;

    // Grants only in SERVE and never while reset is held, which also keeps
    // CEB/WEB deasserted during reset.
    assign w_arb_en = reset && (r_state == SERVE);

    rr_arbiter_2 u_arb (
        .CLK     (CLK),
        .reset   (reset),
        .en      (w_arb_en),
        .req     (req_valid),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx)
    );

    assign w_sel_we    = w_gnt_idx ? req_we[1] : req_we[0];
    assign w_sel_addr  = w_gnt_idx ? req_addr[2*numWordAddr-1:numWordAddr]
                                   : req_addr[numWordAddr-1:0];
    assign w_sel_wdata = w_gnt_idx ? req_wdata[2*numBit-1:numBit]
                                   : req_wdata[numBit-1:0];

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        CEB          = 1'b1;
        WEB          = 1'b1;
        A            = '0;
        D            = '0;
        case (r_state)
            SERVE: begin
                if (|w_gnt) begin
                    CEB = 1'b0;
                    WEB = ~w_sel_we;
                    A   = w_sel_addr;
                    D   = w_sel_wdata;
                end
                // A request granted this cycle still completes; the sweep
                // starts next cycle.
                if (clr_start) begin
                    w_state_next = CLEAR;
                    w_cnt_next   = '0;
                end
            end
            CLEAR: begin
                CEB = 1'b0;
                WEB = 1'b0;
                A   = r_cnt;
                D   = '0;
                // Counter holds at the last address instead of wrapping.
                if (r_cnt == c_last_addr) begin
                    w_state_next = SERVE;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_next = SERVE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_state     <= SERVE;
            r_cnt       <= '0;
            r_rsp_valid <= '0;
            r_clr_done  <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_rsp_valid <= w_gnt & ~req_we;
            r_clr_done  <= (r_state == CLEAR) && (r_cnt == c_last_addr);
        end
    end

    assign req_ready = w_gnt;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = Q;
    assign clr_busy  = (r_state == CLEAR);
    assign clr_done  = r_clr_done;

endmodule : sram_arb_ctrl

`default_nettype wire

// File: tb/tb_sram_arb_ctrl.sv
// ============================================================================
// Module      : tb_sram_arb_ctrl
// Description : Directed self-checking bench for sram_arb_ctrl with a
//               behavioural synchronous SRAM model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sram_arb_ctrl;

    localparam int c_words = 2048;
    localparam int c_bits  = 32;
    localparam int c_aw    = 11;

    logic                CLK = 1'b0;
    logic                reset;
    logic [1:0]          req_valid;
    logic [1:0]          req_we;
    logic [2*c_aw-1:0]   req_addr;
    logic [2*c_bits-1:0] req_wdata;
    logic [1:0]          req_ready;
    logic [1:0]          rsp_valid;
    logic [c_bits-1:0]   rsp_rdata;
    logic                clr_start;
    logic                clr_busy;
    logic                clr_done;
    logic                CEB;
    logic                WEB;
    logic [c_aw-1:0]     A;
    logic [c_bits-1:0]   D;
    logic [c_bits-1:0]   Q;

    logic [c_bits-1:0]   mem [c_words];

    int n_pass  = 0;
    int n_total = 0;

    always #5 CLK = ~CLK;

    sram_arb_ctrl #(
        .numWord (c_words),
        .numBit  (c_bits)
    ) dut (
        .CLK       (CLK),
        .reset     (reset),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .clr_start (clr_start),
        .clr_busy  (clr_busy),
        .clr_done  (clr_done),
        .CEB       (CEB),
        .WEB       (WEB),
        .A         (A),
        .D         (D),
        .Q         (Q)
    );

    // Synchronous SRAM: Q updates only on a read access.
    always @(posedge CLK) begin
        if (!CEB) begin
            if (!WEB) mem[A] <= D;
            else      Q      <= mem[A];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic idle_inputs();
        req_valid = 2'b00;
        req_we    = 2'b00;
        req_addr  = '0;
        req_wdata = '0;
        clr_start = 1'b0;
    endtask

    // Port 1 single write, one cycle.
    task automatic p1_write(input logic [c_aw-1:0] addr, input logic [c_bits-1:0] data);
        req_valid = 2'b10;
        req_we    = 2'b10;
        req_addr  = {addr, {c_aw{1'b0}}};
        req_wdata = {data, {c_bits{1'b0}}};
        #1;
        chk("p1_write_ready", 64'(req_ready), 64'h2);
        tick();
        idle_inputs();
    endtask

    initial begin
        int cnt;
        int bad_ready;
        int bad_addr;
        int budget;

        for (int i = 0; i < c_words; i++) mem[i] = 32'h5A5A_0000 + 32'(i);
        Q = '0;
        idle_inputs();
        reset = 1'b0;

        // Reset state, with requests pending that must not reach the SRAM.
        #12;
        req_valid = 2'b11;
        #1;
        chk("rst_ceb",      64'(CEB),       64'h1);
        chk("rst_web",      64'(WEB),       64'h1);
        chk("rst_ready",    64'(req_ready), 64'h0);
        chk("rst_rspvalid", 64'(rsp_valid), 64'h0);
        chk("rst_busy",     64'(clr_busy),  64'h0);
        chk("rst_done",     64'(clr_done),  64'h0);
        @(negedge CLK);
        idle_inputs();
        reset = 1'b1;

        // Idle cycles.
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("idle_ceb",      64'(CEB),       64'h1);
            chk("idle_web",      64'(WEB),       64'h1);
            chk("idle_rspvalid", 64'(rsp_valid), 64'h0);
            tick();
        end

        // Port 0 writes DEADBEEF to addr 5, port 1 reads it back.
        req_valid = 2'b01;
        req_we    = 2'b01;
        req_addr  = {11'd0, 11'd5};
        req_wdata = {32'h0, 32'hDEAD_BEEF};
        #1;
        chk("wr_ready", 64'(req_ready), 64'h1);
        chk("wr_ceb",   64'(CEB),       64'h0);
        chk("wr_web",   64'(WEB),       64'h0);
        chk("wr_a",     64'(A),         64'd5);
        chk("wr_d",     64'(D),         64'hDEAD_BEEF);
        tick();
        req_valid = 2'b10;
        req_we    = 2'b00;
        req_addr  = {11'd5, 11'd0};
        req_wdata = '0;
        #1;
        chk("rd_ready",    64'(req_ready), 64'h2);
        chk("rd_web",      64'(WEB),       64'h1);
        chk("rd_a",        64'(A),         64'd5);
        chk("rd_rsp_none", 64'(rsp_valid), 64'h0);
        tick();
        idle_inputs();
        #1;
        chk("rd_rspvalid", 64'(rsp_valid), 64'h2);
        chk("rd_rdata",    64'(rsp_rdata), 64'hDEAD_BEEF);
        tick();
        chk("wr_no_rsp", 64'(rsp_valid), 64'h0);

        // Preload via port 1 (keeps last-granted = 1).
        for (int i = 0; i < 4; i++) p1_write(11'(i), 32'hA000_0001 + 32'(i));
        p1_write(11'd10, 32'h1111_0010);
        p1_write(11'd11, 32'h2222_0011);

        // Contention for 4 cycles: port 0 reads 10, port 1 reads 11.
        req_valid = 2'b11;
        req_we    = 2'b00;
        req_addr  = {11'd11, 11'd10};
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_grant", 64'(req_ready), (i % 2 == 0) ? 64'h1 : 64'h2);
            if (i > 0) begin
                chk("rr_rspvalid", 64'(rsp_valid), (i % 2 == 1) ? 64'h1 : 64'h2);
                chk("rr_rdata",    64'(rsp_rdata), (i % 2 == 1) ? 64'h1111_0010 : 64'h2222_0011);
            end
            tick();
        end
        idle_inputs();
        #1;
        chk("rr_last_rspvalid", 64'(rsp_valid), 64'h2);
        chk("rr_last_rdata",    64'(rsp_rdata), 64'h2222_0011);
        tick();

        // Zero-fill sweep with requests held throughout.
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        req_valid = 2'b11;
        #1;
        chk("clr_first_busy", 64'(clr_busy), 64'h1);
        chk("clr_first_ceb",  64'(CEB),      64'h0);
        chk("clr_first_web",  64'(WEB),      64'h0);
        chk("clr_first_a",    64'(A),        64'h0);
        chk("clr_first_d",    64'(D),        64'h0);
        cnt = 0; bad_ready = 0; bad_addr = 0;
        while (clr_busy && cnt < 3000) begin
            if (req_ready !== 2'b00) bad_ready++;
            if (A !== 11'(cnt) || clr_done !== 1'b0) bad_addr++;
            cnt++;
            tick();
        end
        idle_inputs();
        #1;
        chk("clr_len",       64'(cnt),       64'd2048);
        chk("clr_ready_low", 64'(bad_ready), 64'd0);
        chk("clr_addr_seq",  64'(bad_addr),  64'd0);
        chk("clr_done_hi",   64'(clr_done),  64'h1);
        chk("clr_busy_lo",   64'(clr_busy),  64'h0);
        tick();
        chk("clr_done_pulse", 64'(clr_done), 64'h0);

        // Back-to-back reads of addrs 0..3 on port 0 all return zero.
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin
                req_valid = 2'b01;
                req_we    = 2'b00;
                req_addr  = {11'd0, 11'(i)};
            end else begin
                idle_inputs();
            end
            #1;
            if (i > 0) begin
                chk("zero_rspvalid", 64'(rsp_valid), 64'h1);
                chk("zero_rdata",    64'(rsp_rdata), 64'h0);
            end
            tick();
        end

        // clr_start together with a port 0 read of addr 7.
        p1_write(11'd7, 32'h0000_0077);
        clr_start = 1'b1;
        req_valid = 2'b01;
        req_we    = 2'b00;
        req_addr  = {11'd0, 11'd7};
        #1;
        chk("cs_ready", 64'(req_ready), 64'h1);
        chk("cs_web",   64'(WEB),       64'h1);
        chk("cs_a",     64'(A),         64'd7);
        tick();
        idle_inputs();
        #1;
        chk("cs_busy",     64'(clr_busy),  64'h1);
        chk("cs_rspvalid", 64'(rsp_valid), 64'h1);
        chk("cs_rdata",    64'(rsp_rdata), 64'h77);
        cnt = 0;
        while (clr_busy && cnt < 3000) begin
            // A clr_start during the sweep must not restart it.
            clr_start = (cnt == 50);
            cnt++;
            tick();
        end
        clr_start = 1'b0;
        #1;
        chk("cs_len",  64'(cnt),      64'd2048);
        chk("cs_done", 64'(clr_done), 64'h1);
        tick();

        // Reset asserted mid-sweep at counter 100.
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        budget = 0;
        while (A !== 11'd100 && budget < 300) begin
            budget++;
            tick();
        end
        chk("mid_reach100", 64'(A), 64'd100);
        reset = 1'b0;
        req_valid = 2'b11;
        #1;
        chk("mid_ceb",  64'(CEB),      64'h1);
        chk("mid_web",  64'(WEB),      64'h1);
        chk("mid_busy", 64'(clr_busy), 64'h0);
        tick();
        chk("mid_done", 64'(clr_done), 64'h0);
        reset = 1'b1;
        req_valid = 2'b10;
        req_we    = 2'b00;
        req_addr  = {11'd5, 11'd0};
        #1;
        chk("post_rst_grant", 64'(req_ready), 64'h2);
        tick();
        idle_inputs();
        #1;
        chk("post_rst_done",     64'(clr_done),  64'h0);
        chk("post_rst_busy",     64'(clr_busy),  64'h0);
        chk("post_rst_rspvalid", 64'(rsp_valid), 64'h2);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Absolute time bound in case the sequence stalls.
    initial begin
        #200000;
        $display("FAIL timeout observed=stalled expected=finish");
        $fatal(1, "timeout");
    end

endmodule : tb_sram_arb_ctrl

`default_nettype wire
